// File: rtl/ecc_point_index_lut.sv
// ecc_point_index_lut
//   Small table of DEPTH signed (x, y) points with a per-entry valid bit.
//   A lookup request is latched and then compared against one entry per
//   cycle, starting at index 0. The first valid entry whose x and y both
//   equal the request ends the search, so duplicate entries resolve to the
//   lowest index. If no entry matches, the response is a miss at index 0.
//   The response is held until it is consumed.
//
//   Optional feature macro: ECC_PT_DECODE_EN
//     Adds req_op, rsp_x and rsp_y. With req_op=1 the low IW bits of req_x
//     select an entry, and the response returns that entry's contents and
//     its valid bit.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   wr_en/wr_idx/     write {1, wr_x, wr_y} into entry wr_idx
//   wr_x/wr_y
//   tbl_clr           clear all valid bits (a same-cycle write wins)
//   req_valid/        lookup request handshake and coordinates
//   req_ready/
//   req_x/req_y
//   rsp_valid/        response handshake, matched index and hit flag
//   rsp_ready/
//   rsp_idx/rsp_hit
//   req_op, rsp_x,    only with ECC_PT_DECODE_EN
//   rsp_y
module ecc_point_index_lut #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic signed [W-1:0] wr_x,
  input  logic signed [W-1:0] wr_y,
  input  logic                tbl_clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic signed [W-1:0] req_x,
  input  logic signed [W-1:0] req_y,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IW-1:0]       rsp_idx,
  output logic                rsp_hit
`ifdef ECC_PT_DECODE_EN
  ,
  input  logic                req_op,
  output logic signed [W-1:0] rsp_x,
  output logic signed [W-1:0] rsp_y
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);
  localparam logic [IW-1:0] ZERO_IDX = {IW{1'b0}};

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic signed [W-1:0] x_q [DEPTH];
  logic signed [W-1:0] y_q [DEPTH];
  logic signed [W-1:0] req_x_q, req_x_d;
  logic signed [W-1:0] req_y_q, req_y_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]       rsp_idx_q, rsp_idx_d;
  logic                rsp_hit_q, rsp_hit_d;

  logic                accept_s;
  logic                match_s;
  logic                last_s;
  logic                dec_s;
  logic                resolve_s;

`ifdef ECC_PT_DECODE_EN
  logic                op_q, op_d;
  logic signed [W-1:0] rsp_x_q, rsp_x_d;
  logic signed [W-1:0] rsp_y_q, rsp_y_d;
  logic [IW-1:0]       dec_idx_s;
`endif

  assign accept_s = (state_q == ST_IDLE) && req_valid;
  // The compare reads the registered table, so a write in the same cycle
  // only becomes visible to later compares.
  assign match_s  = vld_q[ptr_q] && (x_q[ptr_q] == req_x_q) && (y_q[ptr_q] == req_y_q);
  assign last_s   = (ptr_q == LAST_IDX);

`ifdef ECC_PT_DECODE_EN
  assign dec_idx_s = req_x_q[IW-1:0];
  assign dec_s     = op_q;
`else
  assign dec_s     = 1'b0;
`endif

  // Search step ends on a decode, a match or the last entry.
  assign resolve_s = (state_q == ST_SEARCH) && (dec_s || match_s || last_s);

  // Valid bits: a write to an entry overrides a same-cycle clear.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_idx == IW'(i))) begin
        vld_d[i] = 1'b1;
      end else if (tbl_clr) begin
        vld_d[i] = 1'b0;
      end else begin
        vld_d[i] = vld_q[i];
      end
    end
  end

  // Coordinate storage needs no reset; its valid bit guards every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      x_q[wr_idx] <= wr_x;
      y_q[wr_idx] <= wr_y;
    end
  end

  // State register, search pointer and valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= ZERO_IDX;
      vld_q   <= {DEPTH{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state logic and search pointer advance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SEARCH;
          ptr_d   = ZERO_IDX;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (resolve_s) begin
          state_d = ST_RESP;
        end else begin
          ptr_d = ptr_q + ONE_IDX;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = ZERO_IDX;
      end
    endcase
  end

  // Output and request-latch logic; all outputs come from flops.
  always_comb begin
    req_x_d     = req_x_q;
    req_y_d     = req_y_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
`ifdef ECC_PT_DECODE_EN
    op_d    = op_q;
    rsp_x_d = rsp_x_q;
    rsp_y_d = rsp_y_q;
`endif
    if (accept_s) begin
      req_x_d = req_x;
      req_y_d = req_y;
`ifdef ECC_PT_DECODE_EN
      op_d    = req_op;
`endif
    end else begin
      req_x_d = req_x_q;
      req_y_d = req_y_q;
    end
    if (resolve_s) begin
`ifdef ECC_PT_DECODE_EN
      if (dec_s) begin
        rsp_idx_d = dec_idx_s;
        rsp_hit_d = vld_q[dec_idx_s];
        rsp_x_d   = x_q[dec_idx_s];
        rsp_y_d   = y_q[dec_idx_s];
      end else if (match_s) begin
        rsp_idx_d = ptr_q;
        rsp_hit_d = 1'b1;
        rsp_x_d   = req_x_q;
        rsp_y_d   = req_y_q;
      end else begin
        rsp_idx_d = ZERO_IDX;
        rsp_hit_d = 1'b0;
        rsp_x_d   = {W{1'b0}};
        rsp_y_d   = {W{1'b0}};
      end
`else
      if (match_s) begin
        rsp_idx_d = ptr_q;
        rsp_hit_d = 1'b1;
      end else begin
        rsp_idx_d = ZERO_IDX;
        rsp_hit_d = 1'b0;
      end
`endif
    end else begin
      rsp_idx_d = rsp_idx_q;
      rsp_hit_d = rsp_hit_q;
    end
  end

  // Output and latched-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_x_q     <= {W{1'b0}};
      req_y_q     <= {W{1'b0}};
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= ZERO_IDX;
      rsp_hit_q   <= 1'b0;
`ifdef ECC_PT_DECODE_EN
      op_q        <= 1'b0;
      rsp_x_q     <= {W{1'b0}};
      rsp_y_q     <= {W{1'b0}};
`endif
    end else begin
      req_x_q     <= req_x_d;
      req_y_q     <= req_y_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_hit_q   <= rsp_hit_d;
`ifdef ECC_PT_DECODE_EN
      op_q        <= op_d;
      rsp_x_q     <= rsp_x_d;
      rsp_y_q     <= rsp_y_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_hit   = rsp_hit_q;
`ifdef ECC_PT_DECODE_EN
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
`endif

endmodule

// File: tb/tb_ecc_point_index_lut.sv
// Directed testbench for ecc_point_index_lut (default build; decode
// checks are included when ECC_PT_DECODE_EN is defined).
module tb_ecc_point_index_lut;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int IW    = 4;

  logic                clk;
  logic                rst;
  logic                wr_en;
  logic [IW-1:0]       wr_idx;
  logic signed [W-1:0] wr_x;
  logic signed [W-1:0] wr_y;
  logic                tbl_clr;
  logic                req_valid;
  logic                req_ready;
  logic signed [W-1:0] req_x;
  logic signed [W-1:0] req_y;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IW-1:0]       rsp_idx;
  logic                rsp_hit;
`ifdef ECC_PT_DECODE_EN
  logic                req_op;
  logic signed [W-1:0] rsp_x;
  logic signed [W-1:0] rsp_y;
`endif

  int checks;
  int errors;

  ecc_point_index_lut #(.W(W), .DEPTH(DEPTH), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .tbl_clr   (tbl_clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_idx   (rsp_idx),
    .rsp_hit   (rsp_hit)
`ifdef ECC_PT_DECODE_EN
    ,
    .req_op    (req_op),
    .rsp_x     (rsp_x),
    .rsp_y     (rsp_y)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [IW-1:0] idx, input logic signed [W-1:0] x,
                    input logic signed [W-1:0] y);
    wr_en  = 1'b1;
    wr_idx = idx;
    wr_x   = x;
    wr_y   = y;
    step();
    wr_en  = 1'b0;
  endtask

  // Issue one encode lookup, optionally writing (7,7) into entry 0 during
  // the first compare cycle, and check latency, index and hit.
  task automatic lookup(input string tag, input logic signed [W-1:0] x,
                        input logic signed [W-1:0] y, input bit wr_during,
                        input int exp_k, input logic [IW-1:0] exp_idx,
                        input logic exp_hit);
    int k;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_x     = x;
    req_y     = y;
    step();
    req_valid = 1'b0;
    req_x     = 8'sh25;
    req_y     = 8'sh5A;
    if (wr_during) begin
      wr_en  = 1'b1;
      wr_idx = 4'd0;
      wr_x   = 8'sd7;
      wr_y   = 8'sd7;
    end
    k = 0;
    while (!rsp_valid && k < 40) begin
      step();
      wr_en = 1'b0;
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(exp_k));
    chk({tag, "_idx"}, 32'(rsp_idx), 32'(exp_idx));
    chk({tag, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
  endtask

  // Consume the response and check the return to IDLE.
  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_rise"}, 32'(req_ready), 32'd1);
  endtask

`ifdef ECC_PT_DECODE_EN
  task automatic decode(input string tag, input logic [IW-1:0] idx,
                        input logic exp_hit);
    int k;
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_x     = W'(idx);
    req_y     = 8'sd0;
    step();
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_x     = 8'sh25;
    k = 0;
    while (!rsp_valid && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'd1);
    chk({tag, "_idx"}, 32'(rsp_idx), 32'(idx));
    chk({tag, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = 4'd0;
    wr_x      = 8'sd0;
    wr_y      = 8'sd0;
    tbl_clr   = 1'b0;
    req_valid = 1'b0;
    req_x     = 8'sd0;
    req_y     = 8'sd0;
    rsp_ready = 1'b0;
`ifdef ECC_PT_DECODE_EN
    req_op    = 1'b0;
`endif
    #2 rst = 1'b1;
    step();
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_idx",   32'(rsp_idx),   32'd0);
    chk("rst_rsp_hit",   32'(rsp_hit),   32'd0);
    rst = 1'b0;
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Table load.
    wr(4'd0,  8'sd0, 8'sd0);
    wr(4'd1,  8'sd5, 8'sd0);
    wr(4'd4,  8'sd2, 8'sd1);
    wr(4'd15, 8'sd9, 8'sd10);

    lookup("hit4", 8'sd2, 8'sd1, 1'b0, 5, 4'd4, 1'b1);
    finish_rsp("hit4");
    lookup("hit0", 8'sd0, 8'sd0, 1'b0, 1, 4'd0, 1'b1);
    finish_rsp("hit0");
    lookup("hit15", 8'sd9, 8'sd10, 1'b0, 16, 4'd15, 1'b1);
    finish_rsp("hit15");
    lookup("miss33", 8'sd3, 8'sd3, 1'b0, 16, 4'd0, 1'b0);
    finish_rsp("miss33");

    // Duplicate entry resolves low, response held under backpressure.
    wr(4'd9, 8'sd2, 8'sd1);
    lookup("dup", 8'sd2, 8'sd1, 1'b0, 5, 4'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_vld",   32'(rsp_valid), 32'd1);
      chk("hold_idx",   32'(rsp_idx),   32'd4);
      chk("hold_hit",   32'(rsp_hit),   32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    finish_rsp("dup");

    // A write during the entry-0 compare is not seen by that compare.
    lookup("wr_during", 8'sd7, 8'sd7, 1'b1, 16, 4'd0, 1'b0);
    finish_rsp("wr_during");
    lookup("wr_after", 8'sd7, 8'sd7, 1'b0, 1, 4'd0, 1'b1);
    finish_rsp("wr_after");

    // Clear with a same-cycle write: the written entry survives.
    tbl_clr = 1'b1;
    wr(4'd7, 8'sd6, 8'sd6);
    tbl_clr = 1'b0;
    lookup("clr_miss", 8'sd5, 8'sd0, 1'b0, 16, 4'd0, 1'b0);
    finish_rsp("clr_miss");
    lookup("clr_wr_wins", 8'sd6, 8'sd6, 1'b0, 8, 4'd7, 1'b1);
    finish_rsp("clr_wr_wins");

`ifdef ECC_PT_DECODE_EN
    wr(4'd9, 8'sd9, 8'sd5);
    decode("dec9", 4'd9, 1'b1);
    chk("dec9_x", 32'(rsp_x), 32'd9);
    chk("dec9_y", 32'(rsp_y), 32'd5);
    finish_rsp("dec9");
    decode("dec3", 4'd3, 1'b0);
    finish_rsp("dec3");
`endif

    // Reset in the middle of a search, at ptr=3.
    wr(4'd1, 8'sd5, 8'sd0);
    req_valid = 1'b1;
    req_x     = 8'sd8;
    req_y     = 8'sd8;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst_srch_vld",   32'(rsp_valid), 32'd0);
    chk("rst_srch_ready", 32'(req_ready), 32'd1);
    step();
    rst = 1'b0;
    lookup("post_rst", 8'sd5, 8'sd0, 1'b0, 16, 4'd0, 1'b0);
    finish_rsp("post_rst");

    // Reset while a hit response is being held.
    wr(4'd1, 8'sd5, 8'sd0);
    lookup("pre_rst", 8'sd5, 8'sd0, 1'b0, 2, 4'd1, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_resp_vld", 32'(rsp_valid), 32'd0);
    chk("rst_resp_idx", 32'(rsp_idx),   32'd0);
    chk("rst_resp_hit", 32'(rsp_hit),   32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_resp_ready", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
